// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle W-bit adder that time-shares one 4-bit carry-lookahead slice
// across operand nibbles, LSB first, with a registered carry between passes.

module cla_adder_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [3:0] p, g;
   logic [4:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // Flattened lookahead: every carry comes straight from g/p and cin.
   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & cin_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin_i);

   assign sum_o  = p ^ c[3:0];
   assign cout_o = c[4];
endmodule

module cla_nibble_seq_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [4*NIBBLES-1:0] a_i,
   input  logic [4*NIBBLES-1:0] b_i,
   input  logic                 cin_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [4*NIBBLES-1:0] sum_o,
   output logic                 cout_o,
   output logic                 ovf_o
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
   logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

   logic [3:0]      sl_a, sl_b, sl_sum;
   logic            sl_cout, accept, last;

   assign sl_a = opa_q[4*idx_q +: 4];
   assign sl_b = opb_q[4*idx_q +: 4];

   cla_adder_4bit u_slice (
      .a_i    (sl_a),
      .b_i    (sl_b),
      .cin_i  (carry_q),
      .sum_o  (sl_sum),
      .cout_o (sl_cout)
   );

   assign accept = start_i && (state_q == IDLE || state_q == DONE);
   assign last   = (idx_q == IW'(NIBBLES - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = accept ? RUN : IDLE;
            if (accept) begin
               opa_d   = a_i;
               opb_d   = b_i;
               carry_d = cin_i;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = sl_sum;
            carry_d = sl_cout;
            idx_d   = idx_q + IW'(1);
            if (last) begin
               // Overflow judged on the latched MSBs, not the live inputs.
               cout_d  = sl_cout;
               ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (sl_sum[3] != opa_q[W-1]);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;
endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
Multi-cycle wide adder built from exactly one instance of the existing cla_adder_4bit slice. The slice is time-shared across operand nibbles, LSB first, with a registered carry chained between passes. It uses a start/busy/done handshake and produces a registered sum, carry-out and signed-overflow flag. It is the sequencer that partial-product summation stages of the Vedic multiplier call when a full-width combinational adder is too costly.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when accepting (state IDLE or DONE)
a  input  W  operand A, unsigned or two's complement
b  input  W  operand B
cin  input  1  carry into nibble 0
busy  output  1  high while operation in progress (state RUN)
done  output  1  single-cycle pulse, result valid
sum  output  W  registered result
cout  output  1  carry out of MSB nibble
ovf  output  1  two's-complement overflow of a+b+cin

Behaviour:
- Reset (synchronous, active-high): state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, ovf=0, busy=0, done=0. Holding reset mid-operation abandons the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE); both decoded from registered state.
- IDLE: start=1 at edge E0 -> latch a, b into operand regs, carry reg<=cin, idx<=0, sum<=0, cout<=0, ovf<=0, state<=RUN. start=0 -> stay.
- RUN: slice inputs are operand nibble idx of A and B plus carry reg. The slice's cin port is tied to the carry reg; only the low 4 bits of its sum output are used. Each edge: sum[4*idx+3:4*idx] <= slice sum; carry reg <= slice cout; idx<=idx+1. When idx==NIBBLES-1: cout<=slice cout; ovf<=(A[W-1]==B[W-1]) && (slice sum bit3 != A[W-1]); state<=DONE.
- start while in RUN is ignored: no latch, no queue, no effect on current operation. Inputs a, b, cin may change freely after E0.
- DONE: lasts exactly one cycle. start=1 -> accepted exactly as from IDLE (back-to-back, state<=RUN); otherwise state<=IDLE.
- Latency: for start sampled at E0, busy is high from E0 to E0+NIBBLES. done is high for the single cycle between edges E0+NIBBLES and E0+NIBBLES+1. Throughput is one operation per NIBBLES+1 cycles.
- sum, cout and ovf hold their final values after DONE until the next accepted start clears them. Partial nibbles are visible on sum during RUN and are not guaranteed meaningful.
- Arithmetic: modulo 2^W; cout is the unsigned carry; ovf is the signed overflow, computed from latched operand MSBs.
- Simultaneous reset and start: reset wins.

Test Plan:
- NIBBLES=4: a=16'h1234, b=16'h4321, cin=0, start pulse at E0 -> busy high E0..E4, done pulse between E4 and E5, sum=16'h5555, cout=0, ovf=0.
- Full ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0. Same operands with a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
- Signed overflow: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1. a=16'h8000, b=16'h8000 -> sum=0, cout=1, ovf=1.
- Busy rejection: start a=16'h0010, b=16'h0020 at E0; at E2 drive start=1 with a=16'hAAAA, b=16'h5555 -> exactly one done at E4 with sum=16'h0030; no second done within 10 cycles.
- Back-to-back: start high in the DONE cycle with a=16'h0F0F, b=16'h00F1 -> first result unchanged during its done cycle; second done 4 edges later with sum=16'h1000, cout=0.
- Reset mid-op: assert reset at E2 of an operation -> next edge busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows; a new start afterwards completes correctly.
